// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  // Register 0 is hard-wired zero and never creates a dependency.
  localparam logic [3:0] R0 = 4'd0;

  localparam int unsigned STALL_W = 16;

endpackage

// File: rtl/hazard_ctrl_match.sv
// Compares one pipeline destination register against the two ID-stage sources.
module hazard_ctrl_match
  import hazard_ctrl_pkg::*;
(
  input  logic [3:0] dest,
  input  logic [3:0] src1,
  input  logic       src1_used,
  input  logic [3:0] src2,
  input  logic       src2_used,
  output logic       hit
);

  always_comb begin
    hit = (dest != R0) &&
          ((src1_used && (src1 == dest)) || (src2_used && (src2 == dest)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flush, memory stall, halt drain.
// Build option FULL_RAW_STALL_EN: no forwarding, every RAW against EX or MEM bubbles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned DRAIN   = 3
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         id_src1,
  input  logic               id_src1_used,
  input  logic [3:0]         id_src2,
  input  logic               id_src2_used,
  input  logic               id_branch_tkn,
  input  logic               id_hlt,
  input  logic [3:0]         ex_regaddr,
  input  logic               ex_regwrite,
  input  logic               ex_memtoreg,
  input  logic [3:0]         mem_regaddr,
  input  logic               mem_regwrite,
  input  logic               mem_access,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               idex_en,
  output logic               idex_noop,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               halted,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned DRN_W = $clog2(DRAIN) + 1;
  localparam bit          MEM_STALL_EN = (MEM_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'((DRAIN > 0) ? DRAIN - 1 : 0);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [DRN_W-1:0]   drain, drain_nxt;
  logic               mem_mask, mem_mask_nxt;
  logic               halted_q, halted_nxt;
  logic               stall_inc;
  logic               ex_hit;
  logic               ldu;

  hazard_ctrl_match u_ex_match (
    .dest      (ex_regaddr),
    .src1      (id_src1),
    .src1_used (id_src1_used),
    .src2      (id_src2),
    .src2_used (id_src2_used),
    .hit       (ex_hit)
  );

`ifdef FULL_RAW_STALL_EN
  logic mem_hit;
  logic unused_ex_memtoreg;

  hazard_ctrl_match u_mem_match (
    .dest      (mem_regaddr),
    .src1      (id_src1),
    .src1_used (id_src1_used),
    .src2      (id_src2),
    .src2_used (id_src2_used),
    .hit       (mem_hit)
  );

  // Without forwarding the instruction keeps bubbling until its producer retires past MEM.
  assign ldu = (ex_hit && ex_regwrite) || (mem_hit && mem_regwrite);
  assign unused_ex_memtoreg = ex_memtoreg;
`else
  logic unused_mem_fields;

  assign ldu = ex_hit && ex_regwrite && ex_memtoreg;
  assign unused_mem_fields = ^{mem_regaddr, mem_regwrite};
`endif

  assign halted = halted_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RUN;
      cnt          <= '0;
      drain        <= '0;
      mem_mask     <= 1'b0;
      halted_q     <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      drain    <= drain_nxt;
      mem_mask <= mem_mask_nxt;
      halted_q <= halted_nxt;
      if (stall_inc && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    drain_nxt    = drain;
    mem_mask_nxt = 1'b0;
    halted_nxt   = halted_q;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_noop    = 1'b0;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;

    unique case (state)
      RUN: begin
        // mem_mask covers the cycle the just-finished access is still presented.
        if (MEM_STALL_EN && mem_access && !mem_mask) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_en  = 1'b0;
          memwb_en  = 1'b0;
          cnt_nxt   = CNT_LOAD;
          state_nxt = MEMWAIT;
        end else if (ldu) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_noop = 1'b1;
        end else if (id_branch_tkn) begin
          ifid_flush = 1'b1;
        end else if (id_hlt) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          drain_nxt  = DRN_LOAD;
          state_nxt  = HALT;
        end
      end
      MEMWAIT: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        if (cnt == '0) begin
          state_nxt    = RUN;
          mem_mask_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HALT: begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_noop = 1'b1;
        if (drain == '0) begin
          halted_nxt = 1'b1;
        end else begin
          drain_nxt = drain - 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase

    stall_inc = !pc_en && ((state == RUN) || (state == MEMWAIT));
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_LAT=3, DRAIN=3), queue-based scoreboard.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [3:0] src1;
    logic       s1u;
    logic [3:0] src2;
    logic       s2u;
    logic       br;
    logic       hlt;
    logic [3:0] exa;
    logic       exw;
    logic       exm;
    logic [3:0] mema;
    logic       memw;
    logic       macc;
  } stim_t;

  // Control pattern order: pc_en ifid_en ifid_flush idex_en idex_noop exmem_en memwb_en halted
  localparam logic [7:0] C_OK     = 8'b1101_0110;
  localparam logic [7:0] C_BUB    = 8'b0001_1110;
  localparam logic [7:0] C_FLUSH  = 8'b1111_0110;
  localparam logic [7:0] C_MEM    = 8'b0000_0000;
  localparam logic [7:0] C_HENTER = 8'b0111_0110;
  localparam logic [7:0] C_HDRAIN = 8'b0001_1110;
  localparam logic [7:0] C_HDONE  = 8'b0001_1111;

`ifdef FULL_RAW_STALL_EN
  localparam bit RAW = 1'b1;
`else
  localparam bit RAW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_src1, id_src2, ex_regaddr, mem_regaddr;
  logic        id_src1_used, id_src2_used, id_branch_tkn, id_hlt;
  logic        ex_regwrite, ex_memtoreg, mem_regwrite, mem_access;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_noop, exmem_en, memwb_en, halted;
  logic [15:0] stall_cycles;

  logic [23:0] act;
  logic [23:0] want;
  logic [23:0] exp_q[$];
  logic [15:0] sb_stall = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_LAT(3), .DRAIN(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_src1       (id_src1),
    .id_src1_used  (id_src1_used),
    .id_src2       (id_src2),
    .id_src2_used  (id_src2_used),
    .id_branch_tkn (id_branch_tkn),
    .id_hlt        (id_hlt),
    .ex_regaddr    (ex_regaddr),
    .ex_regwrite   (ex_regwrite),
    .ex_memtoreg   (ex_memtoreg),
    .mem_regaddr   (mem_regaddr),
    .mem_regwrite  (mem_regwrite),
    .mem_access    (mem_access),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .ifid_flush    (ifid_flush),
    .idex_en       (idex_en),
    .idex_noop     (idex_noop),
    .exmem_en      (exmem_en),
    .memwb_en      (memwb_en),
    .halted        (halted),
    .stall_cycles  (stall_cycles)
  );

  assign act = {pc_en, ifid_en, ifid_flush, idex_en, idex_noop, exmem_en, memwb_en, halted,
                stall_cycles};

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst           = s.rst;
    id_src1       = s.src1;
    id_src1_used  = s.s1u;
    id_src2       = s.src2;
    id_src2_used  = s.s2u;
    id_branch_tkn = s.br;
    id_hlt        = s.hlt;
    ex_regaddr    = s.exa;
    ex_regwrite   = s.exw;
    ex_memtoreg   = s.exm;
    mem_regaddr   = s.mema;
    mem_regwrite  = s.memw;
    mem_access    = s.macc;
  endtask

  task automatic test_reset();
    stim_t st[2];
    logic [7:0] ctl[2];
    st[0] = idle(); st[0].rst = 1'b0; ctl[0] = C_OK;
    st[1] = idle();                   ctl[1] = C_OK;
    for (int i = 0; i < 2; i++) begin
      drive(st[i]);
      exp_q.push_back({ctl[i], sb_stall});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL reset[%0d] got=%b/%0d want=%b/%0d", i, act[23:16], act[15:0], want[23:16], want[15:0]);
      end
      if (!st[i].rst) sb_stall = '0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t st[5];
    logic [7:0] ctl[5];
    bit cnt[5];
    st[0] = idle(); st[0].exa = 4'd3; st[0].exw = 1; st[0].exm = 1; st[0].src1 = 4'd3; st[0].s1u = 1;
    ctl[0] = C_BUB; cnt[0] = 1;
    st[1] = idle(); st[1].src1 = 4'd3; st[1].s1u = 1;
    ctl[1] = C_OK; cnt[1] = 0;
    st[2] = idle(); st[2].exa = 4'd7; st[2].exw = 1; st[2].exm = 1;
    st[2].src1 = 4'd2; st[2].s1u = 1; st[2].src2 = 4'd7; st[2].s2u = 1;
    ctl[2] = C_BUB; cnt[2] = 1;
    st[3] = st[2]; st[3].s2u = 0;
    ctl[3] = C_OK; cnt[3] = 0;
    st[4] = st[2]; st[4].exw = 0;
    ctl[4] = C_OK; cnt[4] = 0;
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      exp_q.push_back({ctl[i], sb_stall});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL load_use[%0d] got=%b/%0d want=%b/%0d", i, act[23:16], act[15:0], want[23:16], want[15:0]);
      end
      if (cnt[i]) sb_stall++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_r0();
    stim_t st[3];
    st[0] = idle(); st[0].exw = 1; st[0].exm = 1; st[0].s1u = 1; st[0].s2u = 1;
    st[1] = idle(); st[1].exw = 1; st[1].s1u = 1;
    st[2] = idle(); st[2].memw = 1; st[2].s2u = 1;
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      exp_q.push_back({C_OK, sb_stall});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL r0[%0d] got=%b/%0d want=%b/%0d", i, act[23:16], act[15:0], want[23:16], want[15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ldu_branch();
    stim_t st[3];
    logic [7:0] ctl[3];
    bit cnt[3];
    st[0] = idle(); st[0].exa = 4'd4; st[0].exw = 1; st[0].exm = 1;
    st[0].src1 = 4'd4; st[0].s1u = 1; st[0].br = 1;
    ctl[0] = C_BUB; cnt[0] = 1;
    st[1] = idle(); st[1].src1 = 4'd4; st[1].s1u = 1; st[1].br = 1;
    ctl[1] = C_FLUSH; cnt[1] = 0;
    st[2] = idle(); ctl[2] = C_OK; cnt[2] = 0;
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      exp_q.push_back({ctl[i], sb_stall});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL ldu_branch[%0d] got=%b/%0d want=%b/%0d", i, act[23:16], act[15:0], want[23:16], want[15:0]);
      end
      if (cnt[i]) sb_stall++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_raw();
    stim_t st[3];
    logic [7:0] ctl[3];
    bit cnt[3];
    st[0] = idle(); st[0].exa = 4'd5; st[0].exw = 1;
    st[0].src1 = 4'd1; st[0].s1u = 1; st[0].src2 = 4'd5; st[0].s2u = 1;
    ctl[0] = RAW ? C_BUB : C_OK; cnt[0] = RAW;
    st[1] = idle(); st[1].mema = 4'd5; st[1].memw = 1;
    st[1].src1 = 4'd1; st[1].s1u = 1; st[1].src2 = 4'd5; st[1].s2u = 1;
    ctl[1] = RAW ? C_BUB : C_OK; cnt[1] = RAW;
    st[2] = idle(); st[2].src2 = 4'd5; st[2].s2u = 1;
    ctl[2] = C_OK; cnt[2] = 0;
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      exp_q.push_back({ctl[i], sb_stall});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL full_raw[%0d] got=%b/%0d want=%b/%0d", i, act[23:16], act[15:0], want[23:16], want[15:0]);
      end
      if (cnt[i]) sb_stall++;
      @(posedge clk); #1;
    end
  endtask

  // Three-cycle stall with a held branch, a back-to-back access, then reset inside MEMWAIT.
  task automatic test_mem_stall();
    stim_t st[11];
    logic [7:0] ctl[11];
    bit cnt[11];
    for (int i = 0; i < 11; i++) begin
      st[i] = idle(); st[i].macc = 1; ctl[i] = C_MEM; cnt[i] = 1;
    end
    for (int i = 0; i < 4; i++) st[i].br = 1;
    ctl[3] = C_FLUSH; cnt[3] = 0;
    st[7].macc = 0; ctl[7] = C_OK; cnt[7] = 0;
    st[9].rst = 0;
    st[10].macc = 0; ctl[10] = C_OK; cnt[10] = 0;
    for (int i = 0; i < 11; i++) begin
      drive(st[i]);
      exp_q.push_back({ctl[i], sb_stall});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL mem_stall[%0d] got=%b/%0d want=%b/%0d", i, act[23:16], act[15:0], want[23:16], want[15:0]);
      end
      if (!st[i].rst) sb_stall = '0;
      else if (cnt[i]) sb_stall++;
      @(posedge clk); #1;
    end
  endtask

  // Full drain to halted, reset from halted, then reset in the middle of a second drain.
  task automatic test_halt();
    stim_t st[14];
    logic [7:0] ctl[14];
    bit cnt[14];
    for (int i = 0; i < 14; i++) begin
      st[i] = idle(); ctl[i] = C_HDRAIN; cnt[i] = 0;
    end
    st[0].hlt = 1; ctl[0] = C_HENTER; cnt[0] = 1;
    st[1].br = 1; st[1].macc = 1;
    st[2].macc = 1;
    ctl[4] = C_HDONE; ctl[5] = C_HDONE;
    st[6].rst = 0; ctl[6] = C_HDONE;
    ctl[7] = C_OK;
    st[8].hlt = 1; ctl[8] = C_HENTER; cnt[8] = 1;
    st[11].rst = 0;
    ctl[12] = C_OK; ctl[13] = C_OK;
    for (int i = 0; i < 14; i++) begin
      drive(st[i]);
      exp_q.push_back({ctl[i], sb_stall});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL halt[%0d] got=%b/%0d want=%b/%0d", i, act[23:16], act[15:0], want[23:16], want[15:0]);
      end
      if (!st[i].rst) sb_stall = '0;
      else if (cnt[i]) sb_stall++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    drive(idle());
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_r0();
    test_ldu_branch();
    test_full_raw();
    test_mem_stall();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
